// File: rtl/instr_aligner.sv
// ---------------------------------------------------------------------------
// instr_aligner
// Front-end instruction aligner. Buffers sequential word-aligned 32-bit fetch
// words as halfwords. Emits one aligned instruction per handshake: a 16-bit
// RVC instruction zero-extended, or a 32-bit instruction that may straddle a
// fetch-word boundary. Tracks the PC of the instruction at the buffer head.
//
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   fetch_valid/ready : fetch word handshake
//   fetch_data        : next sequential word, little-endian halfwords
//   fetch_err         : access fault attached to the fetch word
//   instr_valid/ready : decode handshake
//   instr             : aligned instruction (RVC zero-extended in [31:16])
//   instr_pc          : byte address of instr
//   instr_is_rvc      : instr[1:0] != 2'b11
//   instr_fetch_err   : a halfword forming instr carried a fetch fault
//   flush, flush_pc   : redirect; discards all buffered state
// ---------------------------------------------------------------------------
module instr_aligner #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_valid,
   output logic        fetch_ready,
   input  logic [31:0] fetch_data,
   input  logic        fetch_err,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        instr_is_rvc,
   output logic        instr_fetch_err,
   input  logic        flush,
   input  logic [31:0] flush_pc
);

   // hw[0] is the buffer head; slots at or above count are always kept zero
   logic [3:0][15:0] r_hw;
   logic [3:0][15:0] w_hw_n;
   logic [3:0]       r_err;
   logic [3:0]       w_err_n;
   logic [2:0]       r_count;
   logic [2:0]       w_count_n;
   logic [31:0]      r_pc;
   logic [31:0]      w_pc_n;
   logic             r_skip;
   logic             w_skip_n;

   logic             w_rvc;
   logic             w_pop1;
   logic             w_consume;
   logic             w_push;
   logic [1:0]       w_pop;
   logic [2:0]       w_count_ac;
   logic [1:0]       w_slot;
   logic             w_unused_pc_lsb;

   assign w_unused_pc_lsb = flush_pc[0];

   assign w_rvc = (r_hw[0][1:0] != 2'b11);

   // A faulting head halfword with nothing behind it is emitted on its own
   // so a fault never stalls waiting for a second halfword.
   assign instr_valid = ((r_count != 3'd0) && (w_rvc || r_err[0])) ||
                        (r_count >= 3'd2);

   assign instr           = w_rvc ? {16'h0000, r_hw[0]} : {r_hw[1], r_hw[0]};
   assign instr_pc        = r_pc;
   assign instr_is_rvc    = w_rvc;
   assign instr_fetch_err = w_rvc ? r_err[0] : (r_err[0] | r_err[1]);

   // Whenever valid with count==1 the head is either RVC or a lone fault.
   assign w_pop1     = w_rvc || (r_count == 3'd1);
   assign w_consume  = instr_valid && instr_ready;
   assign w_pop      = !w_consume ? 2'd0 : (w_pop1 ? 2'd1 : 2'd2);
   assign w_count_ac = r_count - {1'b0, w_pop};

   assign fetch_ready = !flush && (w_count_ac <= 3'd2);
   assign w_push      = fetch_valid && fetch_ready;
   assign w_slot      = w_count_ac[1:0];

   always_comb begin
      // Pop first (shift down, zero fill), then the push lands after the shift.
      w_hw_n    = r_hw >> {w_pop, 4'b0000};
      w_err_n   = r_err >> w_pop;
      w_count_n = w_count_ac;
      // pc follows the halfwords actually popped so it always names hw[0]
      w_pc_n    = r_pc + {29'd0, w_pop, 1'b0};
      w_skip_n  = r_skip;

      if (w_push) begin
         if (r_skip) begin
            w_hw_n[w_slot]  = fetch_data[31:16];
            w_err_n[w_slot] = fetch_err;
            w_count_n       = w_count_ac + 3'd1;
         end else begin
            w_hw_n[w_slot]          = fetch_data[15:0];
            w_hw_n[w_slot + 2'd1]   = fetch_data[31:16];
            w_err_n[w_slot]         = fetch_err;
            w_err_n[w_slot + 2'd1]  = fetch_err;
            w_count_n               = w_count_ac + 3'd2;
         end
         w_skip_n = 1'b0;
      end

      if (flush) begin
         w_hw_n    = '0;
         w_err_n   = '0;
         w_count_n = '0;
         w_pc_n    = {flush_pc[31:1], 1'b0};
         w_skip_n  = flush_pc[1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hw    <= '0;
         r_err   <= '0;
         r_count <= '0;
         r_pc    <= RESET_PC;
         r_skip  <= RESET_PC[1];
      end else begin
         r_hw    <= w_hw_n;
         r_err   <= w_err_n;
         r_count <= w_count_n;
         r_pc    <= w_pc_n;
         r_skip  <= w_skip_n;
      end
   end

endmodule

// File: tb/tb_instr_aligner.sv
module tb_instr_aligner;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fetch_valid = 1'b0;
   logic        fetch_ready;
   logic [31:0] fetch_data = '0;
   logic        fetch_err = 1'b0;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_is_rvc;
   logic        instr_fetch_err;
   logic        flush = 1'b0;
   logic [31:0] flush_pc = '0;

   int n_checks = 0;
   int n_errors = 0;

   // memory image as halfwords, and the instruction stream it must produce
   logic [15:0] img[$];
   logic [31:0] exp_instr[$];
   logic [31:0] exp_pc[$];
   int          exp_len[$];

   instr_aligner #(.RESET_PC(32'h0000_0000)) dut (
      .clk             (clk),
      .rst             (rst),
      .fetch_valid     (fetch_valid),
      .fetch_ready     (fetch_ready),
      .fetch_data      (fetch_data),
      .fetch_err       (fetch_err),
      .instr_valid     (instr_valid),
      .instr_ready     (instr_ready),
      .instr           (instr),
      .instr_pc        (instr_pc),
      .instr_is_rvc    (instr_is_rvc),
      .instr_fetch_err (instr_fetch_err),
      .flush           (flush),
      .flush_pc        (flush_pc)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic void add_word(input logic [31:0] w);
      img.push_back(w[15:0]);
      img.push_back(w[31:16]);
   endfunction

   // Walk the image from halfword offset 'off': RVC takes 1 halfword, else 2.
   function automatic void build_expected(input logic [31:0] base, input int off);
      int pos;
      logic [15:0] hw;
      exp_instr.delete();
      exp_pc.delete();
      exp_len.delete();
      pos = off;
      while (pos < img.size()) begin
         hw = img[pos];
         if (hw[1:0] != 2'b11) begin
            exp_instr.push_back({16'h0000, hw});
            exp_pc.push_back(base + 32'(2 * pos));
            exp_len.push_back(1);
            pos++;
         end else if (pos + 1 < img.size()) begin
            exp_instr.push_back({img[pos + 1], hw});
            exp_pc.push_back(base + 32'(2 * pos));
            exp_len.push_back(2);
            pos += 2;
         end else begin
            break;
         end
      end
   endfunction

   // mode 0: mixed, 1: all RVC, 2: all 32-bit (final odd halfword forced RVC)
   function automatic void gen_image(input int mode, input int nwords, input int off);
      int pos;
      logic [15:0] hw;
      logic want_rvc;
      img.delete();
      for (int i = 0; i < 2 * nwords; i++) img.push_back(16'($urandom));
      pos = off;
      while (pos < 2 * nwords) begin
         want_rvc = (mode == 1) || (pos == 2 * nwords - 1) ||
                    ((mode == 0) && ($urandom_range(1) == 1));
         if (want_rvc) begin
            hw = 16'($urandom);
            if (hw[1:0] == 2'b11) hw[1:0] = 2'b10;
            img[pos] = hw;
            pos++;
         end else begin
            img[pos]     = {14'($urandom), 2'b11};
            img[pos + 1] = 16'($urandom);
            pos += 2;
         end
      end
   endfunction

   // Starts and ends at posedge+1. Model: an instruction is valid exactly when
   // all of its halfwords have been accepted and not yet consumed.
   task automatic run_stream(input logic [31:0] base, input int off, input int fv_pct,
                             input int rdy_pct, input int stall, input string name);
      int wi = 0, idx = 0, cnt = 0, cyc = 0, pop, nwords;
      logic acc, ev;
      build_expected(base, off);
      nwords = img.size() / 2;
      while (idx < exp_instr.size() && cyc < 4000) begin
         fetch_valid = (wi < nwords) && ($urandom_range(99) < fv_pct);
         fetch_data  = (wi < nwords) ? {img[2 * wi + 1], img[2 * wi]} : $urandom;
         fetch_err   = 1'b0;
         flush       = 1'b0;
         instr_ready = (cyc < stall) ? 1'b0 : ($urandom_range(99) < rdy_pct);
         #2;
         ev = (cnt >= exp_len[idx]);
         check_val({name, ":valid"}, instr_valid, ev);
         if (ev) begin
            check_val({name, ":instr"}, instr, exp_instr[idx]);
            check_val({name, ":pc"}, instr_pc, exp_pc[idx]);
            check_val({name, ":rvc"}, instr_is_rvc, exp_len[idx] == 1);
            check_val({name, ":err"}, instr_fetch_err, 0);
         end
         pop = (ev && instr_ready) ? exp_len[idx] : 0;
         check_val({name, ":fetch_ready"}, fetch_ready, (cnt - pop) <= 2);
         if (stall > 0 && cyc == stall - 1)
            check_val({name, ":bp_full"}, fetch_ready, 0);
         acc = fetch_valid && fetch_ready;
         @(posedge clk);
         if (acc) begin
            cnt += (wi == 0 && off == 1) ? 1 : 2;
            wi++;
         end
         cnt -= pop;
         if (pop != 0) idx++;
         #1;
         cyc++;
      end
      fetch_valid = 1'b0;
      instr_ready = 1'b0;
      check_val({name, ":done"}, idx, exp_instr.size());
      check_val({name, ":drained"}, instr_valid, 0);
   endtask

   task automatic do_flush(input logic [31:0] pc);
      flush       = 1'b1;
      flush_pc    = pc;
      fetch_valid = 1'b1;
      instr_ready = 1'b1;
      fetch_data  = $urandom;
      fetch_err   = 1'b0;
      #2;
      check_val("flush:fetch_ready", fetch_ready, 0);
      step();
      flush       = 1'b0;
      fetch_valid = 1'b0;
      instr_ready = 1'b0;
      check_val("flush:valid", instr_valid, 0);
      check_val("flush:pc", instr_pc, {pc[31:1], 1'b0});
   endtask

   initial begin
      logic [31:0] base;
      int off;

      // reset values
      #12;
      check_val("rst:valid", instr_valid, 0);
      check_val("rst:fetch_ready", fetch_ready, 1);
      check_val("rst:pc", instr_pc, 32'h0);
      check_val("rst:instr", instr, 32'h0);
      check_val("rst:rvc", instr_is_rvc, 1);
      check_val("rst:err", instr_fetch_err, 0);
      @(negedge clk);
      rst = 1'b0;
      step();

      // straight 32-bit stream from reset
      img.delete();
      add_word(32'h0050_0093);
      add_word(32'h00A0_0113);
      run_stream(32'h0, 0, 100, 100, 0, "straight");

      // mixed RVC / straddling 32-bit
      do_flush(32'h0);
      img.delete();
      add_word(32'h0093_4505);
      add_word(32'h0005_0613);
      run_stream(32'h0, 0, 100, 100, 0, "mixed");

      // stale entry buffered, then flush to a halfword address (bit 0 ignored)
      fetch_valid = 1'b1;
      fetch_data  = 32'h1234_5678;
      step();
      fetch_valid = 1'b0;
      check_val("stale:valid", instr_valid, 1);
      do_flush(32'h0000_0103);
      img.delete();
      add_word(32'h4505_0001);
      run_stream(32'h0000_0100, 1, 100, 100, 0, "flush_half");

      // backpressure: decode stalled while fetch streams continuously
      base = $urandom & 32'hFFFF_FFFC;
      off  = $urandom_range(1);
      do_flush(base + 32'(2 * off));
      gen_image(0, 16, off);
      run_stream(base, off, 100, 50, 8, "backpressure");

      // randomized runs, including PC wrap-around
      for (int r = 0; r < 9; r++) begin
         base = (r == 4) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
         off  = $urandom_range(1);
         do_flush(base + 32'(2 * off) + 32'($urandom_range(1)));
         gen_image(r % 3, $urandom_range(6, 24), off);
         run_stream(base, off, $urandom_range(50, 100), $urandom_range(30, 100),
                    (r == 2) ? 6 : 0, "random");
      end

      // fetch fault: 32-bit head with both halfwords present
      do_flush(32'h0000_0200);
      fetch_valid = 1'b1;
      fetch_data  = 32'hABCD_0003;
      fetch_err   = 1'b1;
      #2;
      check_val("faultA:pre_valid", instr_valid, 0);
      step();
      fetch_valid = 1'b0;
      fetch_err   = 1'b0;
      check_val("faultA:valid", instr_valid, 1);
      check_val("faultA:instr", instr, 32'hABCD_0003);
      check_val("faultA:pc", instr_pc, 32'h0000_0200);
      check_val("faultA:err", instr_fetch_err, 1);
      check_val("faultA:rvc", instr_is_rvc, 0);

      // fetch fault: lone 32-bit halfword must not wait for a second one
      do_flush(32'h0000_0206);
      fetch_valid = 1'b1;
      fetch_data  = 32'h0003_BEEF;
      fetch_err   = 1'b1;
      step();
      fetch_valid = 1'b0;
      fetch_err   = 1'b0;
      check_val("faultB:valid", instr_valid, 1);
      check_val("faultB:instr_lo", {16'h0, instr[15:0]}, 32'h0000_0003);
      check_val("faultB:pc", instr_pc, 32'h0000_0206);
      check_val("faultB:err", instr_fetch_err, 1);
      step();
      step();
      check_val("faultB:hold_valid", instr_valid, 1);

      // non-faulting lone 32-bit halfword waits for the next word
      do_flush(32'h0000_020A);
      fetch_valid = 1'b1;
      fetch_data  = 32'h0003_1111;
      step();
      fetch_valid = 1'b0;
      check_val("wait:valid0", instr_valid, 0);
      step();
      check_val("wait:valid1", instr_valid, 0);
      fetch_valid = 1'b1;
      fetch_data  = 32'h5555_0077;
      step();
      fetch_valid = 1'b0;
      check_val("wait:valid2", instr_valid, 1);
      check_val("wait:instr", instr, 32'h0077_0003);
      check_val("wait:pc", instr_pc, 32'h0000_020A);
      check_val("wait:err", instr_fetch_err, 0);

      // flush with fetch_valid and instr_ready while an instruction is pending
      do_flush(32'h0000_0404);
      step();
      check_val("simflush:no_push", instr_valid, 0);
      check_val("simflush:pc", instr_pc, 32'h0000_0404);

      // asynchronous reset with three halfwords buffered
      do_flush(32'h0000_0302);
      fetch_valid = 1'b1;
      fetch_data  = 32'h4505_1111;
      step();
      fetch_data  = 32'h2222_0001;
      step();
      fetch_valid = 1'b0;
      check_val("arst:pre_valid", instr_valid, 1);
      check_val("arst:pre_instr", instr, 32'h0000_4505);
      check_val("arst:pre_pc", instr_pc, 32'h0000_0302);
      #2;
      rst = 1'b1;
      #1;
      check_val("arst:valid", instr_valid, 0);
      check_val("arst:pc", instr_pc, 32'h0);
      check_val("arst:fetch_ready", fetch_ready, 1);
      @(negedge clk);
      rst = 1'b0;
      step();

      // stream again straight out of reset
      gen_image(0, 10, 0);
      run_stream(32'h0, 0, 80, 80, 0, "post_reset");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/instr_aligner.md
# instr_aligner

Front-end instruction aligner that produces the `instr` word consumed by `instr_decode`. It accepts a stream of consecutive word-aligned 32-bit fetch words and buffers them as halfwords. It emits one aligned instruction per handshake: a 16-bit RVC instruction zero-extended, or a 32-bit instruction that may straddle a fetch-word boundary. It sits between the fetch response path and the decode stage, and tracks the PC of every emitted instruction.

## Interface
- `RESET_PC`, default 32'h0000_0000, PC of the first instruction after reset. Bit 0 must be 0.
- `clk` input 1: single clock, all state on rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `fetch_valid` input 1: `fetch_data` is valid.
- `fetch_ready` output 1: aligner accepts the word this cycle.
- `fetch_data` input 32: next sequential fetch word, little-endian halfwords.
- `fetch_err` input 1: access fault on this word.
- `instr_valid` output 1: `instr` / `instr_pc` are valid.
- `instr_ready` input 1: decode consumes the instruction this cycle.
- `instr` output 32: aligned instruction. RVC instructions are zero-extended in [31:16].
- `instr_pc` output 32: byte address of `instr`.
- `instr_is_rvc` output 1: `instr[1:0]` != 2'b11.
- `instr_fetch_err` output 1: a halfword forming `instr` carried `fetch_err`.
- `flush` input 1: redirect. Discards all buffered state.
- `flush_pc` input 32: new PC. Bit 0 is ignored and treated as 0.

## Operation
- **State**
  - 4-entry halfword buffer `hw[0..3]`, each with an err bit.
  - `count` in 0..4.
  - `pc`: PC of `hw[0]`.
  - `skip` flag: drop the lower halfword of the next accepted word.
- **Fetch handshake**
  - `fetch_ready` = !flush && (count_after_consume <= 2).
  - count_after_consume = count minus the halfwords popped this cycle (2 if a 32-bit instruction is consumed, 1 if RVC, 0 otherwise).
  - The transfer occurs when `fetch_valid` && `fetch_ready`.
- **Push**
  - If `skip`=0, `fetch_data[15:0]` goes to slot count_after_consume and `[31:16]` to the next slot; count increases by 2.
  - If `skip`=1, only `[31:16]` is pushed; count increases by 1 and `skip` clears.
  - Both halfwords take the word's `fetch_err`.
- **Emit**
  - `instr_valid` = (count>=1 && hw[0][1:0]!=2'b11) || (count>=2).
  - A 32-bit instruction with count==1 waits for the second halfword.
  - An RVC instruction emits {16'h0, hw[0]}. A 32-bit instruction emits {hw[1], hw[0]}.
  - `instr_fetch_err` is err[0] for RVC, and err[0]|err[1] for 32-bit.
  - If err[0]=1 and count==1, emit immediately with `instr_fetch_err`=1, treated as a 32-bit instruction that pops 1 halfword. A fault must not stall waiting for a second halfword.
- **Consume** (`instr_valid` && `instr_ready`)
  - Pop 1 or 2 halfwords and shift the remaining entries down.
  - `pc` advances by 2 (RVC) or 4 (32-bit), with 32-bit wrap-around.
- **Concurrency**: consume and push in the same cycle are both performed. The push lands after the shift.
- **Flush** has priority over everything in the same cycle.
  - count becomes 0, `pc` becomes {flush_pc[31:1], 1'b0}, `skip` becomes flush_pc[1].
  - No push and no consume take effect that cycle.
  - Upstream guarantees that the next accepted word is the word at {flush_pc[31:2], 2'b00}.
- **Reset**: count=0, pc=RESET_PC, skip=RESET_PC[1].

## Timing
- Outputs are combinational from registered state only. There is no combinational path from `fetch_*` or `instr_ready` to `instr`, `instr_pc`, or `instr_valid`.
- `fetch_ready` depends combinationally on `flush`, `instr_ready`, and state.
- Latency: a word accepted in cycle N can be emitted in cycle N+1.
- Throughput: one instruction per cycle sustained for all-32-bit or all-RVC streams, provided upstream supplies a word every cycle when needed.
- **Reset values**
  - `instr_valid`=0, `fetch_ready`=1, `instr_pc`=RESET_PC.
  - `instr`, `instr_is_rvc`, and `instr_fetch_err` are driven from cleared buffer contents, which are all 0.
- `instr` and `instr_pc` are held stable while `instr_valid` && !`instr_ready`, unless `flush` is asserted.
- An asynchronous `rst` mid-stream discards the buffer immediately. `instr_valid` drops without waiting for a clock.

## Test plan
- **Reset, straight 32-bit stream**: RESET_PC=0, words 0x00500093 and 0x00A00113, `instr_ready`=1.
  - Instructions emitted at pc 0x0 and 0x4, `instr_is_rvc`=0.
  - `fetch_ready` stays 1.
- **Mixed RVC**: word 0x00934505 (c.li at pc 0, then the low half of a 32-bit instruction), next word 0x00050613.
  - Emits 0x00004505 at pc 0, then 0x06130093 at pc 2 spanning both words, then RVC 0x0005 at pc 6.
- **Flush to a halfword address**: flush_pc=0x102, then word 0x4505_0001 accepted.
  - Lower halfword dropped; emits 0x00004505 at pc 0x102.
  - Any stale buffered entries from before the flush are never emitted.
- **Backpressure**: hold `instr_ready`=0 with continuous `fetch_valid`.
  - Buffer fills to count 3 or 4, then `fetch_ready`=0.
  - `instr` stays stable.
  - Releasing `instr_ready` resumes with no lost or duplicated halfwords, checked against a byte-stream model.
- **Fetch fault**: first word has `fetch_err`=1 with low halfword 0x0003.
  - Emits immediately with `instr_fetch_err`=1 at the current pc, even if no second word arrives.
- **Simultaneous events**
  - `flush` together with `fetch_valid` and `instr_ready`: no pop, no push, `pc`=flush_pc.
  - Asynchronous `rst` while count=3: `instr_valid` goes to 0 before the next clock edge.
